// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding and default timing.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 868;
    localparam int unsigned DATA_BITS_DEF    = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pin inputs; resets to 1 (idle-high lines).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver feeding a downstream FIFO; flags framing errors and overruns.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 Pclk,
    input  logic                 RESET_N,
    input  logic                 ENABLE,
    input  logic                 RX,
    input  logic                 FIFO_FULL,
    input  logic                 CLR_ERR,
    output logic [DATA_BITS-1:0] DATA_OUT,
    output logic                 PUSH,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN,
    output logic                 BUSY
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    uart_state_e          state_q,   state_d;
    logic [CNT_W-1:0]     timer_q,   timer_d;
    logic [IDX_W-1:0]     idx_q,     idx_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [DATA_BITS-1:0] data_q,    data_d;
    logic                 push_q,    push_d;
    logic                 ferr_q,    ferr_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q,    busy_d;
    logic                 ovr_set;

    sync_2ff u_rx_sync (
        .clk   (Pclk),
        .rst_n (RESET_N),
        .d     (RX),
        .q     (rx_s)
    );

    // Frame sequencing, bit timing and result generation.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        push_d  = 1'b0;
        ferr_d  = 1'b0;
        ovr_set = 1'b0;

        if (!ENABLE) begin
            state_d = ST_IDLE;
            timer_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d = ST_START;
                        timer_d = '0;
                    end
                end
                ST_START: begin
                    if (timer_q == HALF_M1) begin
                        timer_d = '0;
                        idx_d   = '0;
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (timer_q == FULL_M1) begin
                        timer_d = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        idx_d   = idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (timer_q == FULL_M1) begin
                        timer_d = '0;
                        if (!rx_s) begin
                            ferr_d  = 1'b1;
                            state_d = ST_WAIT_HIGH;
                        end else begin
                            state_d = ST_IDLE;
                            if (FIFO_FULL) begin
                                ovr_set = 1'b1;
                            end else begin
                                push_d = 1'b1;
                                data_d = shift_q;
                            end
                        end
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    // Hold off until a break releases so it cannot look like a new start bit.
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end

        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (CLR_ERR) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Pclk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            push_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            push_q    <= push_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
        end
    end

    assign DATA_OUT  = data_q;
    assign PUSH      = push_q;
    assign FRAME_ERR = ferr_q;
    assign OVERRUN   = overrun_q;
    assign BUSY      = busy_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that deserialises 8N1 UART frames from the board RX pin.
- Writes each received byte into the downstream fifo through its DATA_IN/PUSH/FULL interface.
- Sits directly upstream of the input FIFO in the keyboard/host-command path.
- Flags framing errors, and flags overruns when the FIFO is full.

Parameters:
- CLKS_PER_BIT, 868, Pclk cycles per bit (100 MHz / 115200). Must be >= 4.
- DATA_BITS, 8, payload bits per frame, sent LSB first.
- CNT_W, $clog2(CLKS_PER_BIT), bit-timer width. Derived; do not set directly.

Ports:
- Pclk  in  1  system clock; all logic is on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  block active when 1.
- RX  in  1  asynchronous serial line; idles high.
- FIFO_FULL  in  1  FULL output of the downstream fifo.
- CLR_ERR  in  1  synchronous clear of the sticky OVERRUN flag.
- DATA_OUT  out  DATA_BITS  received byte; connects to fifo DATA_IN.
- PUSH  out  1  one-cycle write strobe; connects to fifo PUSH.
- FRAME_ERR  out  1  one-cycle pulse on a bad stop bit.
- OVERRUN  out  1  sticky; set when a valid byte is dropped because FIFO_FULL=1.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RESET_N=0, async):
  - Both synchroniser flops go to 1, state=IDLE, timer=0, bit index=0, shift register=0.
  - DATA_OUT=0, PUSH=0, FRAME_ERR=0, OVERRUN=0, BUSY=0.
  - Reset mid-frame abandons the frame; nothing is pushed.
- Synchroniser: RX passes through two flops to give rx_s. All decisions use rx_s only.
- ENABLE=0 (synchronous): state=IDLE, timer=0, PUSH=0, FRAME_ERR=0. OVERRUN and DATA_OUT hold.
- IDLE: rx_s==0 -> START with timer=0.
- START: timer counts up to CLKS_PER_BIT/2-1 (integer division), giving a mid-bit sample.
  - rx_s==0 at that count -> DATA, timer=0, bit index=0.
  - rx_s==1 at that count -> IDLE. This is glitch rejection; no error is flagged.
- DATA:
  - When timer==CLKS_PER_BIT-1: shift rx_s into the MSB of the shift register (shift right), timer=0, bit index+1.
  - After the DATA_BITS-th sample -> STOP.
- STOP, when timer==CLKS_PER_BIT-1:
  - rx_s==1, FIFO_FULL==0: next cycle PUSH=1 for exactly one cycle and DATA_OUT=byte. -> IDLE.
  - rx_s==1, FIFO_FULL==1: no PUSH, OVERRUN<=1. -> IDLE.
  - rx_s==0: FRAME_ERR=1 for one cycle, no PUSH. -> WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then -> IDLE. This prevents a break condition from retriggering START.
- DATA_OUT holds its last pushed value until the next push.
- OVERRUN clears only on CLR_ERR=1. If a set and CLR_ERR occur in the same cycle, set wins.
- Latency from the RX falling edge to PUSH high:
  - 2 cycles (sync) + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles.
  - Small uncertainty from the sync stages is acceptable.
- FIFO handshake:
  - PUSH never asserts while FIFO_FULL was sampled 1 in the same cycle.
  - PUSH asserts at most once per frame. Minimum PUSH spacing is 9.5 bit times.
- Back-to-back frames: a start bit immediately after the stop sample is accepted. IDLE is entered on the stop-sample cycle, so no extra idle bit is required.

Decomposition:
- Package uart_pkg holds:
  - state encoding constants: ST_IDLE=0, ST_START=1, ST_DATA=2, ST_STOP=3, ST_WAIT_HIGH=4, 3-bit;
  - default CLKS_PER_BIT=868 and DATA_BITS=8.
- One sub-module, sync_2ff: a two-flop synchroniser with reset value 1 and async active-low reset. It is reused later for other pin inputs.
- The FSM, bit timer and shift register stay in uart_rx.

Test Plan (all tests use CLKS_PER_BIT=16; the bench also instantiates fifo as the consumer):
- Frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), valid stop -> exactly one PUSH, DATA_OUT=0xA5, fifo pops 0xA5, FRAME_ERR=0, OVERRUN=0.
- RX low for 4 cycles then high -> state returns to IDLE, no PUSH, no FRAME_ERR, BUSY drops within 12 cycles.
- Frame 0x3C with stop bit=0, line then held low 40 cycles -> one FRAME_ERR pulse, no PUSH, BUSY stays 1 until RX returns high.
- FIFO_FULL=1, frame 0x55 -> no PUSH, OVERRUN=1 stays set through a following good frame 0x12 (pushed, FIFO_FULL=0); CLR_ERR pulse -> OVERRUN=0.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two PUSHes 160 cycles apart, values 0x00 then 0xFF.
- RESET_N pulsed low mid-DATA of 0x7E, then a clean 0x81 -> no PUSH for 0x7E, all outputs at reset values during reset, one PUSH with 0x81 afterwards.
